// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Walks a wide operand pair through an external 4-bit adder one nibble per cycle,
// chaining carry, and returns the registered wide sum over valid/ready.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_cin,
    output logic [NIBBLE_W-1:0]         adder_a,
    output logic [NIBBLE_W-1:0]         adder_b,
    output logic                        adder_cin,
    input  logic [NIBBLE_W-1:0]         adder_s,
    input  logic                        adder_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic             last_nibble;

    assign last_nibble = (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)    state_nxt = ST_RUN;
            ST_RUN:  if (last_nibble) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; adder is driven with zeros outside RUN
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                busy      = 1'b1;
                adder_a   = a_reg[NIBBLE_W*32'(idx) +: NIBBLE_W];
                adder_b   = b_reg[NIBBLE_W*32'(idx) +: NIBBLE_W];
                adder_cin = carry;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: adder return is only sampled in RUN so X elsewhere never lands in a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    out_sum[NIBBLE_W*32'(idx) +: NIBBLE_W] <= adder_s;
                    carry <= adder_cout;
                    if (last_nibble) begin
                        out_cout <= adder_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl with NIBBLES=4 and a 4-bit adder model.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_s;
    logic         adder_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .busy       (busy)
    );

    // External 4-bit ripple adder
    assign {adder_cout, adder_s} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // Carry entering nibble i is the overflow of the low 4*i bits of a+b+cin
    function automatic logic ref_carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input int i);
        longint unsigned mask;
        longint unsigned part;
        if (i == 0) return cin;
        mask = (64'd1 << (4 * i)) - 64'd1;
        part = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
        return part[4*i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair from IDLE and let the accepting edge pass
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, recording adder_cin per RUN cycle; returns edges since accept
    task automatic wait_done(output int lat, output logic [7:0] cin_trace);
        lat = 1;
        cin_trace = '0;
        while (!out_valid && lat < 40) begin
            cin_trace[lat-1] = adder_cin;
            step();
            lat++;
        end
        lat--;
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done_timeout: got out_valid=0 expected 1");
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int lat;
        logic [7:0] tr;
        start_op(vecs[k].a, vecs[k].b, vecs[k].cin);
        chk($sformatf("v%0d_busy_run", k), 32'(busy), 32'd1);
        wait_done(lat, tr);
        chk($sformatf("v%0d_latency", k), 32'(lat), 32'(NIB));
        chk($sformatf("v%0d_sum", k), 32'(out_sum), 32'(vecs[k].exp_sum));
        chk($sformatf("v%0d_cout", k), 32'(out_cout), 32'(vecs[k].exp_cout));
        for (int i = 0; i < int'(NIB); i++)
            chk($sformatf("v%0d_adder_cin_n%0d", k, i), 32'(tr[i]),
                32'(ref_carry_into(vecs[k].a, vecs[k].b, vecs[k].cin, i)));
        release_result();
        chk($sformatf("v%0d_idle_after", k), {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        logic [7:0] tr;
        logic [W-1:0] held;
        logic [W:0] exp_q[$];
        logic [W:0] r;
        int sent;
        int got;
        int cycles;
        logic in_fire;
        logic out_fire;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_adder_drive", {23'd0, adder_cin, adder_a, adder_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 6; k++) run_vec(k);

        // Backpressure in DONE with in_valid pulses that must be ignored
        start_op(16'h2222, 16'h3333, 1'b1);
        wait_done(lat, tr);
        held = out_sum;
        chk("bp_sum_entry", 32'(held), 32'h5556);
        for (int c = 0; c < 5; c++) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_valid = c[0];
            step();
            chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_sum_c%0d", c), 32'(out_sum), 32'(held));
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("bp_cout", 32'(out_cout), 32'd0);
        release_result();
        chk("bp_back_idle", {30'd0, in_ready, busy}, 32'd2);

        // Reset in the second RUN cycle discards the operation
        start_op(16'hABCD, 16'h1111, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_sum", 32'(out_sum), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_vec(5);

        // Randomised traffic with output stalls against a queue-based model
        sent = 0;
        got = 0;
        cycles = 0;
        while (got < 200 && cycles < 20000) begin
            if (!in_valid && sent < 200 && ($urandom % 3) != 0) begin
                in_a = 16'($urandom);
                in_b = 16'($urandom);
                in_cin = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom);
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_result", 32'(out_sum), 32'hDEAD_0000);
                end else begin
                    r = exp_q.pop_front();
                    chk($sformatf("rand_sum_%0d", got), 32'(out_sum), 32'(r[W-1:0]));
                    chk($sformatf("rand_cout_%0d", got), 32'(out_cout), 32'(r[W]));
                end
                got++;
            end
            step();
            cycles++;
            if (in_fire) begin
                exp_q.push_back(ref_add(in_a, in_b, in_cin));
                sent++;
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("rand_results_count", 32'(got), 32'd200);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
